multi_blink_counter: RTL and testbench

MULTI_BLINK_COUNTER -- requirements
Module: multi_blink_counter

---
 rtl/multi_blink_counter.sv | 134 +++++++++++++
 tb/tb_multi_blink_counter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_blink_counter.sv
// -----------------------------------------------------------------------------
// multi_blink_counter
//
// A shared free-running prescaler produces a one-cycle tick once every
// 2^LOG2DELAY clocks. Each tick can step any number of independent channel
// counters. Each channel is either free-running (wraps) or one-shot (stops at
// its terminal value and raises a sticky done flag). A single load port can
// overwrite any one channel at any time.
//
// Optional feature (compile-time macro MULTI_BLINK_PWM_EN):
//   When defined, each channel drives a PWM output. The output is high while
//   the top BITS bits of the prescaler are below that channel's count. This
//   requires LOG2DELAY >= BITS. When the macro is undefined, pwm is tied to 0
//   and no comparators are built.
//
// Parameters:
//   BITS       width of each channel counter
//   LOG2DELAY  prescaler width (tick period = 2^LOG2DELAY clocks)
//   CHANNELS   number of channels, 1..16
//
// Ports:
//   clk       clock, all state changes on rising edge
//   rst_n     asynchronous active-low reset
//   en        per-channel count enable
//   dir       per-channel direction (0 = up, 1 = down)
//   oneshot   per-channel mode (0 = free-run wrap, 1 = stop at terminal)
//   load      load strobe for channel load_ch
//   load_ch   channel index to load (values >= CHANNELS are ignored)
//   load_val  value written on load
//   tick      one-cycle pulse while the prescaler is all-ones
//   count     packed channel values, channel i at [i*BITS +: BITS]
//   done      per-channel sticky terminal flag (one-shot mode only)
//   pwm       per-channel duty-cycle output
// -----------------------------------------------------------------------------
module multi_blink_counter #(
  parameter int BITS      = 4,
  parameter int LOG2DELAY = 22,
  parameter int CHANNELS  = 2
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [CHANNELS-1:0]                              en,
  input  logic [CHANNELS-1:0]                              dir,
  input  logic [CHANNELS-1:0]                              oneshot,
  input  logic                                             load,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_ch,
  input  logic [BITS-1:0]                                  load_val,
  output logic                                             tick,
  output logic [CHANNELS*BITS-1:0]                         count,
  output logic [CHANNELS-1:0]                              done,
  output logic [CHANNELS-1:0]                              pwm
);

  logic [LOG2DELAY-1:0] prescaler_q;
  logic [LOG2DELAY-1:0] prescaler_d;
  logic [BITS-1:0]      count_q [CHANNELS];
  logic [BITS-1:0]      count_d [CHANNELS];
  logic [CHANNELS-1:0]  done_q;
  logic [CHANNELS-1:0]  done_d;
  logic [BITS-1:0]      step_val;
  logic [BITS-1:0]      term_val;

  // The prescaler reset value is 0, so tick is low during reset automatically.
  assign tick = &prescaler_q;

  always_comb begin
    prescaler_d = prescaler_q + LOG2DELAY'(1);
  end

  // Per-channel next state. Load has priority over stepping. done is only
  // retained while the channel stays in one-shot mode, so leaving one-shot
  // clears it on the following edge.
  always_comb begin
    step_val = '0;
    term_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_d[i] = count_q[i];
      done_d[i]  = done_q[i] & oneshot[i];
      if (load && (int'(load_ch) == i)) begin
        count_d[i] = load_val;
        done_d[i]  = 1'b0;
      end else if (tick && en[i]) begin
        step_val = dir[i] ? (count_q[i] - BITS'(1)) : (count_q[i] + BITS'(1));
        term_val = dir[i] ? '0 : '1;
        if (!oneshot[i]) begin
          count_d[i] = step_val;
        end else if (!done_q[i]) begin
          // A channel already sitting on its terminal value only flags done.
          if (count_q[i] == term_val) begin
            done_d[i] = 1'b1;
          end else begin
            count_d[i] = step_val;
            if (step_val == term_val) begin
              done_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      done_q      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      prescaler_q <= prescaler_d;
      done_q      <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign done = done_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count_out
    assign count[g*BITS +: BITS] = count_q[g];
  end

`ifdef MULTI_BLINK_PWM_EN
  // The top BITS bits of the prescaler act as a sawtooth reference, so a
  // count of N yields a duty cycle of N/2^BITS. Count 0 keeps pwm low.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_pwm
    assign pwm[g] = (prescaler_q[LOG2DELAY-1 -: BITS] < count_q[g]);
  end
`else
  assign pwm = '0;
`endif

endmodule

// File: tb/tb_multi_blink_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_blink_counter
//
// Self-checking bench for multi_blink_counter. A behavioural model tracks
// the prescaler as an integer cycle counter and each channel as an integer
// value with modular arithmetic. Every clock, the tick, count, done and pwm
// outputs are compared against the model. Directed steps cover the reset
// sequence, wrap, direction change, one-shot, load priority, out-of-range
// load, and a mid-run reset. A randomized phase follows.
//
// Three channels are used so that load_ch is 2 bits wide and an
// out-of-range index (3) can be driven.
// -----------------------------------------------------------------------------
module tb_multi_blink_counter;

  localparam int BITS     = 4;
  localparam int CHANNELS = 3;
`ifdef MULTI_BLINK_PWM_EN
  localparam int LOG2DELAY = 6;
`else
  localparam int LOG2DELAY = 3;
`endif
  localparam int PERIOD = 1 << LOG2DELAY;
  localparam int MODV   = 1 << BITS;

  logic                     clk;
  logic                     rst_n;
  logic [CHANNELS-1:0]      en;
  logic [CHANNELS-1:0]      dir;
  logic [CHANNELS-1:0]      oneshot;
  logic                     load;
  logic [1:0]               load_ch;
  logic [BITS-1:0]          load_val;
  logic                     tick;
  logic [CHANNELS*BITS-1:0] count;
  logic [CHANNELS-1:0]      done;
  logic [CHANNELS-1:0]      pwm;

  int checks;
  int errors;

  // Model state
  int mPresc;
  int mCount [CHANNELS];
  bit mDone  [CHANNELS];
  bit mStepEdge;

  multi_blink_counter #(
    .BITS     (BITS),
    .LOG2DELAY(LOG2DELAY),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .dir     (dir),
    .oneshot (oneshot),
    .load    (load),
    .load_ch (load_ch),
    .load_val(load_val),
    .tick    (tick),
    .count   (count),
    .done    (done),
    .pwm     (pwm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITS-1:0] getCount(input int ch);
    return count[ch*BITS +: BITS];
  endfunction

  task automatic modelReset();
    mPresc    = 0;
    mStepEdge = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      mCount[i] = 0;
      mDone[i]  = 1'b0;
    end
  endtask

  // Advances the model by one rising edge, using the inputs currently applied.
  task automatic modelEdge();
    bit tickNow;
    int c;
    int nc;
    int term;
    bit nd;
    tickNow = (mPresc == PERIOD - 1);
    for (int i = 0; i < CHANNELS; i++) begin
      c  = mCount[i];
      nc = c;
      nd = oneshot[i] ? mDone[i] : 1'b0;
      if (load && (int'(load_ch) == i)) begin
        nc = int'(load_val);
        nd = 1'b0;
      end else if (tickNow && en[i]) begin
        if (!oneshot[i]) begin
          nc = dir[i] ? (c + MODV - 1) % MODV : (c + 1) % MODV;
        end else if (!mDone[i]) begin
          term = dir[i] ? 0 : MODV - 1;
          if (c != term) nc = dir[i] ? c - 1 : c + 1;
          if (nc == term) nd = 1'b1;
        end
      end
      mCount[i] = nc;
      mDone[i]  = nd;
    end
    mPresc    = (mPresc + 1) % PERIOD;
    mStepEdge = tickNow;
  endtask

  task automatic checkOutput();
    logic [CHANNELS*BITS-1:0] expCount;
    logic [CHANNELS-1:0]      expDone;
    logic [CHANNELS-1:0]      expPwm;
    for (int i = 0; i < CHANNELS; i++) begin
      expCount[i*BITS +: BITS] = BITS'(mCount[i]);
      expDone[i] = mDone[i];
`ifdef MULTI_BLINK_PWM_EN
      expPwm[i] = ((mPresc >> (LOG2DELAY - BITS)) < mCount[i]);
`else
      expPwm[i] = 1'b0;
`endif
    end
    checkValue("tick",  32'(tick),  32'(mPresc == PERIOD - 1));
    checkValue("count", 32'(count), 32'(expCount));
    checkValue("done",  32'(done),  32'(expDone));
    checkValue("pwm",   32'(pwm),   32'(expPwm));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic runCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) runCycle();
  endtask

  // Runs until n step edges (edges ending a tick-high cycle) have passed.
  task automatic runTicks(input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      do begin
        runCycle();
        guard++;
      end while (!mStepEdge && guard <= PERIOD + 1);
    end
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] e, input logic [CHANNELS-1:0] d,
                               input logic [CHANNELS-1:0] o);
    en      = e;
    dir     = d;
    oneshot = o;
  endtask

  task automatic loadChannel(input logic [1:0] ch, input logic [BITS-1:0] val);
    load     = 1'b1;
    load_ch  = ch;
    load_val = val;
    runCycle();
    load     = 1'b0;
  endtask

  // Asynchronous reset pulse of half a clock period straddling a rising edge.
  task automatic resetPulse();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("rst_count", 32'(count), 32'd0);
    checkValue("rst_done",  32'(done),  32'd0);
    checkValue("rst_tick",  32'(tick),  32'd0);
    checkValue("rst_pwm",   32'(pwm),   32'd0);
    #4;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    load_ch  = '0;
    load_val = '0;
    applyStimulus(3'b011, 3'b000, 3'b000);
    modelReset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkValue("reset_count", 32'(count), 32'd0);
    checkValue("reset_done",  32'(done),  32'd0);
    checkValue("reset_tick",  32'(tick),  32'd0);
    checkValue("reset_pwm",   32'(pwm),   32'd0);
    rst_n = 1'b1;

    // First tick arrives PERIOD-1 clocks after release
    runCycles(PERIOD - 2);
    checkValue("first_tick_low", 32'(tick), 32'd0);
    runCycles(1);
    checkValue("first_tick_high", 32'(tick), 32'd1);

    // Free-running up count wraps after 16 steps
    runTicks(1);
    checkValue("up_count0_1", 32'(getCount(0)), 32'd1);
    runTicks(15);
    checkValue("wrap_count0", 32'(getCount(0)), 32'd0);
    checkValue("wrap_count1", 32'(getCount(1)), 32'd0);
    checkValue("idle_count2", 32'(getCount(2)), 32'd0);

    // Channel 1 counts down from 0
    applyStimulus(3'b011, 3'b010, 3'b000);
    runTicks(1);
    checkValue("down_count1_15", 32'(getCount(1)), 32'd15);
    checkValue("up_count0_1b",   32'(getCount(0)), 32'd1);
    runTicks(1);
    checkValue("down_count1_14", 32'(getCount(1)), 32'd14);
    checkValue("up_count0_2",    32'(getCount(0)), 32'd2);

    // One-shot up on channel 0 from 13
    applyStimulus(3'b011, 3'b000, 3'b001);
    loadChannel(2'd0, 4'd13);
    runTicks(1);
    checkValue("os_count_14", 32'(getCount(0)), 32'd14);
    checkValue("os_done_0",   32'(done[0]),     32'd0);
    runTicks(1);
    checkValue("os_count_15", 32'(getCount(0)), 32'd15);
    checkValue("os_done_1",   32'(done[0]),     32'd1);
    runTicks(3);
    checkValue("os_hold_15",  32'(getCount(0)), 32'd15);
    checkValue("os_hold_done", 32'(done[0]),    32'd1);
    loadChannel(2'd0, 4'd2);
    checkValue("os_load_done", 32'(done[0]),    32'd0);
    checkValue("os_load_val",  32'(getCount(0)), 32'd2);

    // Load wins over a simultaneous step
    for (int g = 0; g < 2 * PERIOD && mPresc != PERIOD - 1; g++) runCycle();
    checkValue("align_tick", 32'(tick), 32'd1);
    loadChannel(2'd0, 4'd9);
    checkValue("load_prio", 32'(getCount(0)), 32'd9);
    loadChannel(2'd3, 4'd5);
    checkValue("load_oob",  32'(getCount(0)), 32'd9);

    // Mid-run asynchronous reset
    applyStimulus(3'b011, 3'b000, 3'b000);
    loadChannel(2'd0, 4'd6);
    runCycles(1);
    checkValue("pre_reset_6", 32'(getCount(0)), 32'd6);
    resetPulse();
    runCycles(PERIOD - 2);
    checkValue("post_reset_tick_low", 32'(tick), 32'd0);
    runCycles(1);
    checkValue("post_reset_tick", 32'(tick), 32'd1);

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        applyStimulus(3'($urandom), 3'($urandom), 3'($urandom));
      end
      load     = ($urandom_range(0, 5) == 0);
      load_ch  = 2'($urandom_range(0, 3));
      load_val = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        load = 1'b0;
        resetPulse();
      end else begin
        runCycle();
      end
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
